// File: rtl/rgb565_pixel_packer.sv
// Packs RGB565 pixels in pairs into 32-bit words, queues them in a FIFO and
// serves them through a custom-instruction port (STATUS / POP / CLEAR).
// Ports:
//   clock, reset        - sole clock (rising edge), async active-low reset
//   pixelValid/Data     - incoming RGB565 pixel stream
//   frameStart          - start-of-frame marker, drops any held half pixel
//   start/valueA/valueB - custom-instruction request (opcode in valueA[1:0])
//   isId                - instruction ID, compared with customInstructionID
//   done/result         - instruction completion and result (same cycle)
//   overflow            - sticky flag, a completed word was dropped
module rgb565_pixel_packer #(
  parameter logic [7:0]  customInstructionID = 8'd0,
  parameter int unsigned FIFO_DEPTH          = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pixelValid,
  input  logic [15:0] pixelData,
  input  logic        frameStart,
  input  logic        start,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  input  logic [7:0]  isId,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t          state, state_next;
  logic [31:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [15:0]     half_data;
  logic            half_valid;

  logic            is_me;
  logic [1:0]      opcode;
  logic            empty, full;
  logic [31:0]     head, status;
  logic            pair_done, push, push_ok, drop;
  logic            pop, clear;
  logic            done_int;
  logic [31:0]     result_int;

  // Upper opcode bits and valueB carry no meaning for this block.
  logic            unused_bits;
  assign unused_bits = ^{valueA[31:2], valueB};

  assign is_me     = start && (isId == customInstructionID);
  assign opcode    = valueA[1:0];
  assign empty     = (count == '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign head      = mem[rd_ptr];
  assign status    = {overflow, 22'b0, half_valid, 8'(count)};

  // A word completes when a second pixel lands on a held half (not on frameStart).
  assign pair_done = pixelValid && !frameStart && half_valid;
  assign push      = pair_done && !clear;
  assign push_ok   = push && (!full || pop);
  assign drop      = push && full && !pop;

  // Instruction FSM: next state, completion and FIFO side effects.
  always_comb begin
    state_next = state;
    done_int   = 1'b0;
    result_int = '0;
    pop        = 1'b0;
    clear      = 1'b0;
    case (state)
      IDLE: begin
        if (is_me) begin
          case (opcode)
            2'd0: begin
              done_int   = 1'b1;
              result_int = status;
            end
            2'd1: begin
              if (!empty) begin
                done_int   = 1'b1;
                result_int = head;
                pop        = 1'b1;
              end else begin
                state_next = WAIT;
              end
            end
            2'd2: begin
              done_int = 1'b1;
              clear    = 1'b1;
            end
            default: done_int = 1'b1;
          endcase
        end
      end
      WAIT: begin
        if (!is_me) begin
          state_next = IDLE;
        end else if (!empty) begin
          done_int   = 1'b1;
          result_int = head;
          pop        = 1'b1;
          state_next = IDLE;
        end else if (frameStart) begin
          done_int   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held.
  assign done   = done_int && reset;
  assign result = reset ? result_int : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // FIFO pointers, occupancy, overflow and the half-pixel register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      half_data  <= '0;
      half_valid <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      half_valid <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
      if (drop) overflow <= 1'b1;
      if (frameStart) begin
        half_valid <= pixelValid;
        if (pixelValid) half_data <= pixelData;
      end else if (pixelValid) begin
        if (half_valid) begin
          half_valid <= 1'b0;
        end else begin
          half_valid <= 1'b1;
          half_data  <= pixelData;
        end
      end
    end
  end

  // Word storage; contents need no reset.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= {pixelData, half_data};
  end

endmodule
